// File: rtl/des_key_schedule.sv
// des_key_schedule: DES round-subkey generator fed by the PC-1 output, streaming K1..K16 (or K16..K1).
// Optional feature macro: DES_KS_DECRYPT_EN enables decrypt order (right rotations); otherwise decrypt is ignored.
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [56:1] key_in,
    input  logic        decrypt,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic [3:0]  round,
    output logic        last
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST_N = 4'(NUM_ROUNDS - 1);

    state_t      r_state;
    logic [56:1] r_cd;
    logic [3:0]  r_n;
    logic        r_dec;
    logic        r_key_ready;
    logic        r_subkey_valid;
    logic        w_load;
    logic        w_xfer;
    logic        w_one;
    logic        w_dec_in;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

`ifdef DES_KS_DECRYPT_EN
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign w_dec_in = decrypt;
    assign w_c_nxt  = r_dec ? rotr(r_cd[56:29], w_one) : rotl(r_cd[56:29], w_one);
    assign w_d_nxt  = r_dec ? rotr(r_cd[28:1], w_one)  : rotl(r_cd[28:1], w_one);
`else
    // decrypt is read but forced off, so only the encrypt order exists
    assign w_dec_in = decrypt & 1'b0;
    assign w_c_nxt  = rotl(r_cd[56:29], w_one);
    assign w_d_nxt  = rotl(r_cd[28:1], w_one);
`endif

    // Steps 0, 7 and 14 move to a key whose shift is 1 in both directions; all others shift by 2
    assign w_one  = (r_n == 4'd0) || (r_n == 4'd7) || (r_n == 4'd14);
    assign w_load = key_valid & r_key_ready;
    assign w_xfer = r_subkey_valid & subkey_ready;

    assign key_ready    = r_key_ready;
    assign subkey_valid = r_subkey_valid;
    assign round        = r_dec ? 4'd15 - r_n : r_n;
    assign last         = r_subkey_valid && (r_n == LAST_N);

    // PC-2 is pure wiring: FIPS bit j of CD is r_cd[57-j]
    assign subkey = {r_cd[43], r_cd[40], r_cd[46], r_cd[33], r_cd[56], r_cd[52],
                     r_cd[54], r_cd[29], r_cd[42], r_cd[51], r_cd[36], r_cd[47],
                     r_cd[34], r_cd[38], r_cd[45], r_cd[53], r_cd[31], r_cd[49],
                     r_cd[41], r_cd[50], r_cd[30], r_cd[37], r_cd[44], r_cd[55],
                     r_cd[16], r_cd[5],  r_cd[26], r_cd[20], r_cd[10], r_cd[2],
                     r_cd[27], r_cd[17], r_cd[6],  r_cd[12], r_cd[24], r_cd[9],
                     r_cd[13], r_cd[8],  r_cd[18], r_cd[1],  r_cd[23], r_cd[4],
                     r_cd[11], r_cd[15], r_cd[7],  r_cd[21], r_cd[28], r_cd[25]};

    // Load/stream FSM; C/D only rotate between keys, never after the final transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cd           <= '0;
            r_n            <= '0;
            r_dec          <= 1'b0;
            r_key_ready    <= 1'b1;
            r_subkey_valid <= 1'b0;
        end else if (w_load) begin
            r_state        <= RUN;
            r_key_ready    <= 1'b0;
            r_subkey_valid <= 1'b1;
            r_n            <= '0;
            r_dec          <= w_dec_in;
            r_cd           <= w_dec_in ? key_in : {rotl(key_in[56:29], 1'b1), rotl(key_in[28:1], 1'b1)};
        end else if (w_xfer) begin
            if (r_n == LAST_N) begin
                r_state        <= IDLE;
                r_key_ready    <= 1'b1;
                r_subkey_valid <= 1'b0;
            end else begin
                r_n  <= r_n + 4'd1;
                r_cd <= {w_c_nxt, w_d_nxt};
            end
        end
    end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed checks of the DES key schedule against the classic 133457799BBCDFF1 subkeys.
module tb_des_key_schedule;
    localparam logic [55:0] KEY = 56'hF0CCAAF556678F;
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
`ifdef DES_KS_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_valid4 = 1'b0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b1;
    logic [55:0] key_in = KEY;
    logic        key_ready, subkey_valid, last;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        key_ready4, subkey_valid4, last4;
    logic [47:0] subkey4;
    logic [3:0]  round4;
    int          tests = 0;
    int          fails = 0;

    des_key_schedule u_dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .decrypt(decrypt), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey(subkey), .round(round), .last(last)
    );

    des_key_schedule #(.NUM_ROUNDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .key_valid(key_valid4), .key_ready(key_ready4),
        .key_in(key_in), .decrypt(1'b0), .subkey_valid(subkey_valid4),
        .subkey_ready(1'b1), .subkey(subkey4), .round(round4), .last(last4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int k, input int e);
        chk({tag, " subkey"}, subkey, KS[e]);
        chk({tag, " round"}, round, 48'(e));
        chk({tag, " valid"}, 48'(subkey_valid), 48'(1));
        chk({tag, " last"}, 48'(last), 48'(k == 15));
    endtask

    task automatic load(input logic dec);
        decrypt = dec;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        decrypt = 1'b0;
    endtask

    initial begin
        repeat (2) tick;
        rst = 1'b0;
        tick;
        chk("reset key_ready", 48'(key_ready), 48'(1));
        chk("reset valid", 48'(subkey_valid), 48'(0));
        chk("reset subkey", subkey, 48'h0);
        chk("reset round", 48'(round), 48'(0));
        chk("reset last", 48'(last), 48'(0));

        load(1'b0);
        for (int k = 0; k < 16; k++) begin
            step("enc", k, k);
            chk("enc key_ready busy", 48'(key_ready), 48'(0));
            tick;
        end
        chk("enc done key_ready", 48'(key_ready), 48'(1));
        chk("enc done valid", 48'(subkey_valid), 48'(0));

        load(1'b1);
        for (int k = 0; k < 16; k++) begin
            step("dec", k, DEC_EN ? 15 - k : k);
            tick;
        end
        chk("dec done key_ready", 48'(key_ready), 48'(1));

        load(1'b0);
        for (int k = 0; k < 16; k++) begin
            step("bp", k, k);
            if (k == 4) begin
                subkey_ready = 1'b0;
                repeat (3) begin
                    tick;
                    chk("bp stall subkey", subkey, KS[4]);
                    chk("bp stall round", 48'(round), 48'(4));
                    chk("bp stall valid", 48'(subkey_valid), 48'(1));
                end
                subkey_ready = 1'b1;
            end
            tick;
        end
        chk("bp done key_ready", 48'(key_ready), 48'(1));

        load(1'b0);
        for (int k = 0; k < 16; k++) begin
            step("ign", k, k);
            if (k == 5) begin
                key_in = 56'h0123456789ABCD;
                key_valid = 1'b1;
            end
            if (k == 6) key_valid = 1'b0;
            if (k == 15) begin
                key_in = KEY;
                key_valid = 1'b1;
            end
            tick;
        end
        chk("no same-cycle reload ready", 48'(key_ready), 48'(1));
        chk("no same-cycle reload valid", 48'(subkey_valid), 48'(0));
        tick;
        key_valid = 1'b0;
        step("reload", 0, 0);

        for (int k = 1; k < 8; k++) begin
            tick;
            step("pre-rst", k, k);
        end
        rst = 1'b1;
        #1;
        chk("rst valid", 48'(subkey_valid), 48'(0));
        chk("rst subkey", subkey, 48'h0);
        chk("rst key_ready", 48'(key_ready), 48'(1));
        #2;
        rst = 1'b0;
        tick;
        chk("post-rst idle valid", 48'(subkey_valid), 48'(0));
        chk("post-rst idle ready", 48'(key_ready), 48'(1));
        load(1'b0);
        step("post-rst", 0, 0);
        for (int k = 1; k < 16; k++) begin
            tick;
            step("post-rst", k, k);
        end
        tick;

        key_valid4 = 1'b1;
        tick;
        key_valid4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("r4 subkey", subkey4, KS[k]);
            chk("r4 round", 48'(round4), 48'(k));
            chk("r4 last", 48'(last4), 48'(k == 3));
            chk("r4 valid", 48'(subkey_valid4), 48'(1));
            tick;
        end
        chk("r4 done ready", 48'(key_ready4), 48'(1));
        chk("r4 done valid", 48'(subkey_valid4), 48'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
